// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with stall, flush, valid bit and immediate formatting
// Optional bubble counter output enabled by defining ID_EX_PERF_EN.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int MEM_W  = 3,
  parameter int EXE_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WB_W+MEM_W+EXE_W-1:0]   decoder_in,
  input  logic [DATA_W-1:0]             dataA_in,
  input  logic [DATA_W-1:0]             dataB_in,
  input  logic [31:0]                   instr_in,
  input  logic                          ls,
  input  logic [1:0]                    imm_mode,
  output logic                          out_valid,
  output logic [WB_W-1:0]               WB_out,
  output logic [MEM_W-1:0]              MEM_out,
  output logic [EXE_W-1:0]              EXE_out,
  output logic [REG_W-1:0]              RS_out,
  output logic [REG_W-1:0]              RT_out,
  output logic [REG_W-1:0]              RD_out,
  output logic [DATA_W-1:0]             dataA_out,
  output logic [DATA_W-1:0]             dataB_out,
  output logic [DATA_W-1:0]             imm_out
`ifdef ID_EX_PERF_EN
  ,
  output logic [15:0]                   bubble_cnt
`endif
);

  localparam int CTRL_W = WB_W + MEM_W + EXE_W;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [REG_W-1:0]  rs_q, rs_d;
  logic [REG_W-1:0]  rt_q, rt_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  logic [DATA_W-1:0] imm_q, imm_d;

  logic [15:0]       imm_raw;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_fmt;

  // Opcode bits never reach EX; upper specifier bits drop when REG_W < 5.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_in[31:26], instr_in[20:16]};

  assign imm_raw  = instr_in[15:0];
  assign imm_sext = {{(DATA_W-16){imm_raw[15]}}, imm_raw};
  assign imm_zext = DATA_W'(imm_raw);

  always_comb begin
    imm_fmt = imm_sext;
    case (imm_mode)
      2'b00: imm_fmt = imm_sext;
      2'b01: imm_fmt = imm_zext;
      2'b10: imm_fmt = imm_zext << 16;
      2'b11: imm_fmt = imm_sext << 2;
      default: imm_fmt = imm_sext;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    imm_d    = imm_q;
    if (flush) begin
      valid_d  = 1'b0;
      ctrl_d   = '0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      data_a_d = '0;
      data_b_d = '0;
      imm_d    = '0;
    end else if (!stall) begin
      valid_d  = in_valid;
      ctrl_d   = in_valid ? decoder_in : '0;
      rs_d     = instr_in[21 +: REG_W];
      rt_d     = instr_in[16 +: REG_W];
      rd_d     = instr_in[11 +: REG_W];
      data_a_d = ls ? DATA_W'(instr_in[25:21]) : dataA_in;
      data_b_d = dataB_in;
      imm_d    = imm_fmt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      imm_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      imm_q    <= imm_d;
    end
  end

  assign out_valid = valid_q;
  assign WB_out    = ctrl_q[CTRL_W-1 -: WB_W];
  assign MEM_out   = ctrl_q[EXE_W +: MEM_W];
  assign EXE_out   = ctrl_q[EXE_W-1:0];
  assign RS_out    = rs_q;
  assign RT_out    = rt_q;
  assign RD_out    = rd_q;
  assign dataA_out = data_a_q;
  assign dataB_out = data_b_q;
  assign imm_out   = imm_q;

`ifdef ID_EX_PERF_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_in;

  // A bubble enters EX on a flush or on a load of an empty decode slot.
  assign bubble_in = flush || (!stall && !in_valid);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_in && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt_q <= '0;
    else
      bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, ls;
  logic [8:0]  decoder_in;
  logic [31:0] dataA_in, dataB_in, instr_in;
  logic [1:0]  imm_mode;
  logic        out_valid;
  logic [1:0]  WB_out;
  logic [2:0]  MEM_out;
  logic [3:0]  EXE_out;
  logic [4:0]  RS_out, RT_out, RD_out;
  logic [31:0] dataA_out, dataB_out, imm_out;
`ifdef ID_EX_PERF_EN
  logic [15:0] bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .decoder_in (decoder_in),
    .dataA_in   (dataA_in),
    .dataB_in   (dataB_in),
    .instr_in   (instr_in),
    .ls         (ls),
    .imm_mode   (imm_mode),
    .out_valid  (out_valid),
    .WB_out     (WB_out),
    .MEM_out    (MEM_out),
    .EXE_out    (EXE_out),
    .RS_out     (RS_out),
    .RT_out     (RT_out),
    .RD_out     (RD_out),
    .dataA_out  (dataA_out),
    .dataB_out  (dataB_out),
    .imm_out    (imm_out)
`ifdef ID_EX_PERF_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] dec, input logic [31:0] ins,
                       input logic [1:0] mode, input logic l,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid   = v;
    decoder_in = dec;
    instr_in   = ins;
    imm_mode   = mode;
    ls         = l;
    dataA_in   = a;
    dataB_in   = b;
  endtask

  task automatic check_bubble(input string tag, input logic [15:0] exp);
`ifdef ID_EX_PERF_EN
    check(tag, bubble_cnt, exp);
`endif
  endtask

  logic [31:0] imm_exp [4];

  initial begin
    imm_exp[0] = 32'hFFFF8000;
    imm_exp[1] = 32'h00008000;
    imm_exp[2] = 32'h80000000;
    imm_exp[3] = 32'hFFFE0000;

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 9'h1A5, 32'h8C22FFFC, 2'b00, 1'b0, 32'h11, 32'h22);
    cyc(); cyc();
    check("rst_valid", out_valid, 0);
    check("rst_wb", WB_out, 0);
    check("rst_mem", MEM_out, 0);
    check("rst_exe", EXE_out, 0);
    check("rst_rs", RS_out, 0);
    check("rst_dataA", dataA_out, 0);
    check("rst_imm", imm_out, 0);
    check_bubble("rst_bubble", 16'd0);

    rst = 1'b0;
    cyc();
    check("ld_valid", out_valid, 1);
    check("ld_wb", WB_out, 2'b11);
    check("ld_mem", MEM_out, 3'b010);
    check("ld_exe", EXE_out, 4'h5);
    check("ld_rs", RS_out, 5'd1);
    check("ld_rt", RT_out, 5'd2);
    check("ld_rd", RD_out, 5'd31);
    check("ld_imm", imm_out, 32'hFFFFFFFC);
    check("ld_dataA", dataA_out, 32'h11);
    check("ld_dataB", dataB_out, 32'h22);

    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 9'h1A5, 32'h3C018000, 2'(m), 1'b0, 32'h11, 32'h22);
      cyc();
      check($sformatf("imm_mode%0d", m), imm_out, imm_exp[m]);
    end

    drive(1'b1, 9'h1A5, 32'h02200000, 2'b00, 1'b1, 32'hDEADBEEF, 32'h22);
    cyc();
    check("ls_dataA", dataA_out, 32'h00000011);

    drive(1'b0, 9'h1FF, 32'h8C22FFFC, 2'b00, 1'b0, 32'h33, 32'h34);
    cyc();
    check("inv_valid", out_valid, 0);
    check("inv_wb", WB_out, 0);
    check("inv_exe", EXE_out, 0);
    check("inv_rs", RS_out, 5'd1);
    check("inv_dataA", dataA_out, 32'h33);
    check_bubble("inv_bubble", 16'd1);

    drive(1'b1, 9'h0F3, 32'h012A5820, 2'b00, 1'b0, 32'hA0, 32'hB0);
    cyc();
    check("pre_stall_wb", WB_out, 2'b01);
    check("pre_stall_mem", MEM_out, 3'b111);
    check("pre_stall_rs", RS_out, 5'd9);
    check("pre_stall_rt", RT_out, 5'd10);
    check("pre_stall_rd", RD_out, 5'd11);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 9'h1A5, 32'h8C22FFFC + i, 2'b01, 1'b0, 32'h44 + i, 32'h55 + i);
      cyc();
      check($sformatf("stall%0d_valid", i), out_valid, 1);
      check($sformatf("stall%0d_exe", i), EXE_out, 4'h3);
      check($sformatf("stall%0d_rd", i), RD_out, 5'd11);
      check($sformatf("stall%0d_dataA", i), dataA_out, 32'hA0);
      check($sformatf("stall%0d_imm", i), imm_out, 32'h00005820);
      check_bubble($sformatf("stall%0d_bubble", i), 16'd1);
    end
    stall = 1'b0;
    drive(1'b1, 9'h1A5, 32'h8C22FFFC, 2'b01, 1'b0, 32'h44, 32'h55);
    cyc();
    check("post_stall_wb", WB_out, 2'b11);
    check("post_stall_dataB", dataB_out, 32'h55);
    check("post_stall_imm", imm_out, 32'h0000FFFC);

    stall = 1'b1; flush = 1'b1;
    cyc();
    check("sf_valid", out_valid, 0);
    check("sf_wb", WB_out, 0);
    check("sf_mem", MEM_out, 0);
    check("sf_exe", EXE_out, 0);
    check("sf_dataA", dataA_out, 0);
    check("sf_imm", imm_out, 0);
    check_bubble("sf_bubble", 16'd2);

    stall = 1'b0;
    cyc();
    check("fl_valid", out_valid, 0);
    check("fl_rd", RD_out, 0);
    check_bubble("fl_bubble", 16'd3);
    flush = 1'b0;
    cyc();
    check("after_fl_valid", out_valid, 1);
    check_bubble("after_fl_bubble", 16'd3);

`ifdef ID_EX_PERF_EN
    in_valid = 1'b0;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    check("sat_bubble", bubble_cnt, 16'hFFFF);
    rst = 1'b1;
    cyc();
    check("sat_rst_bubble", bubble_cnt, 16'd0);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Parametrised ID/EX pipeline register, the successor to the fixed 32-bit decode stage register.
- Sits between register-file read/decoder and the execute stage.
- Adds synchronous reset, stall (hold), flush (bubble insert), a valid bit and selectable immediate extension.
- Captures decoder control fields, register specifiers, operands and the formatted immediate every enabled cycle.

Parameters:
- DATA_W, 32, operand/immediate width; must be >= 32.
- REG_W, 5, register specifier width; must be <= 5.
- WB_W, 2, write-back control field width.
- MEM_W, 3, memory control field width.
- EXE_W, 4, execute control field width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold all outputs
- flush  in  1  replace next stage contents with a bubble
- in_valid  in  1  current decode slot holds a real instruction
- decoder_in  in  WB_W+MEM_W+EXE_W  control word {WB, MEM, EXE}, WB in the MSBs
- dataA_in  in  DATA_W  register-file port A
- dataB_in  in  DATA_W  register-file port B
- instr_in  in  32  fetched instruction word
- ls  in  1  dataA_out takes instr[25:21] instead of dataA_in
- imm_mode  in  2  immediate format select
- out_valid  out  1  EX slot holds a real instruction
- WB_out  out  WB_W  WB control
- MEM_out  out  MEM_W  MEM control
- EXE_out  out  EXE_W  EXE control
- RS_out  out  REG_W  instr[25:21], low REG_W bits
- RT_out  out  REG_W  instr[20:16], low REG_W bits
- RD_out  out  REG_W  instr[15:11], low REG_W bits
- dataA_out  out  DATA_W  operand A
- dataB_out  out  DATA_W  operand B
- imm_out  out  DATA_W  formatted immediate

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Every output is 0 the cycle after rst is sampled high, including out_valid and any optional counter.
- Latency: one cycle, input to output.
- Priority each edge is rst > flush > stall > load.
- Flush:
  - out_valid, WB_out, MEM_out, EXE_out, RS_out, RT_out and RD_out go to 0.
  - dataA_out, dataB_out and imm_out go to 0.
  - Flush wins over a simultaneous stall; the bubble is inserted and the held instruction is discarded.
- Stall (no flush): all outputs hold their previous values, including out_valid.
- Load: taken when none of rst, flush or stall is high.
  - out_valid <= in_valid.
  - If in_valid=1, WB/MEM/EXE are loaded from decoder_in.
  - If in_valid=0, WB/MEM/EXE are 0. Register and data fields are still captured from the inputs.
  - RS/RT/RD are taken from their instr bit fields.
  - dataA_out <= ls ? zero-extended instr[25:21] : dataA_in.
  - dataB_out <= dataB_in.
- Immediate, with imm = instr[15:0]:
  - 00: sign-extend to DATA_W.
  - 01: zero-extend.
  - 10: imm placed at bits [31:16], bits [15:0] zero, upper bits above 31 zero.
  - 11: sign-extend, then shift left 2 (branch offset); bits shifted out of the top are discarded.
- Combinational paths: none from input to output; all outputs are registered.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - Adds output bubble_cnt, 16 bits.
  - Increments on every edge where a bubble enters EX (a flush, or a load with in_valid=0).
  - Holds during stall without flush.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset then load:
  - Stimulus: rst for 2 cycles, then in_valid=1, decoder_in=9'h1A5, instr=32'h8C22FFFC, imm_mode=00, ls=0, dataA=32'h11, dataB=32'h22.
  - Response, next cycle: WB=2'b11, MEM=3'b010, EXE=4'h5, RS=1, RT=2, RD=31, imm=32'hFFFFFFFC, dataA=32'h11, dataB=32'h22, out_valid=1.
- Immediate modes on instr=32'h3C018000:
  - 00 -> imm_out=32'hFFFF8000.
  - 01 -> imm_out=32'h00008000.
  - 10 -> imm_out=32'h80000000.
  - 11 -> imm_out=32'hFFFE0000.
- ls=1 with instr[25:21]=5'd17, dataA_in=32'hDEADBEEF -> dataA_out=32'h00000011.
- Stall:
  - Stimulus: load a value, then raise stall for 3 cycles while changing all inputs.
  - Response: outputs are unchanged for those 3 cycles; the new inputs appear 1 cycle after stall drops.
- Stall and flush together: stall=1 and flush=1 in the same cycle -> out_valid=0 and WB/MEM/EXE=0 next cycle; with ID_EX_PERF_EN, bubble_cnt increments by 1.
- Counter saturation (ID_EX_PERF_EN): 65540 consecutive in_valid=0 loads -> bubble_cnt=16'hFFFF; then rst -> bubble_cnt=0.
